nn_sequence_ctrl: RTL
=====================

# nn_sequence_ctrl

Sequencer for the single-input, single-output neural-network ALU datapath. It handles one input sample per run through all hidden neurons: coefficient load, X-multiply, activation, Y-multiply and accumulate, then the output offset add. It generates every enable and select line of the datapath, owns the accumulator feedback register and the result register, and presents a Start/Done handshake to the host.

## Interface
- Width, 32: fixed-point word width (Q9.22 signed in the default build).
- Neurons, 10: hidden neurons per run. Legal range is 1..10.
- CLK  in  1  clock. All state changes on the rising edge.
- reset  in  1  synchronous, active-high. Sampled on the CLK edge.
- Start  in  1  run request. Sampled only in IDLE.
- DataIn  in  Width  input sample. Captured when Start is accepted.
- SumIn  in  Width  datapath sum output (OutDato).
- ErrorIn  in  1  datapath overflow/error flag.
- InDato  out  Width  captured sample, held for the whole run.
- Acumulador  out  Width  accumulator fed back to the datapath adder.
- EnableLoadCoeff, EnableMulX, EnableRegOutMultCoeffX, EnableFuctAct, EnableRegActFunc, EnableMulY, EnableRegDesplazamiento, EnableSum  out  1 each  datapath enables.
- SELCoeffX, SELCoeffY  out  4  neuron index.
- SELOffset  out  1  selects the offset into the adder.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle completion pulse.
- Result  out  Width  final network output, held until the next completion.
- ErrorOut  out  1  sticky error for the current or last run.

## Operation
- States: IDLE → LOAD → MULX → ACT → MULY → (MULX for the next neuron | OFFSET) → DONE → IDLE.
- All datapath enables and selects are Moore outputs decoded from the state register and the neuron counter `idx`. No enables are asserted in IDLE or DONE.
- IDLE, Start=1: InDato <= DataIn, idx <= 0, Acumulador <= 0, ErrorOut <= 0, go to LOAD.
- LOAD: EnableLoadCoeff=1.
- MULX: EnableMulX=1, EnableRegOutMultCoeffX=1, SELCoeffX=idx.
- ACT: EnableFuctAct=1, EnableRegActFunc=1.
- MULY: EnableMulY=1, EnableRegDesplazamiento=1, EnableSum=1, SELOffset=0, SELCoeffY=idx, Acumulador <= SumIn.
  - If idx==Neurons-1, go to OFFSET.
  - Otherwise idx <= idx+1 and go to MULX.
- OFFSET: EnableSum=1, SELOffset=1, Result <= SumIn, go to DONE.
- DONE: Done=1, go to IDLE.
- Outside LOAD, MULX and MULY, SELCoeffX and SELCoeffY hold idx, so the selects change only on neuron transitions.
- ErrorOut: in every non-IDLE state, ErrorOut <= ErrorOut | ErrorIn. It is cleared only on Start acceptance or reset.
- The controller performs no arithmetic. Acumulador and Result are plain Width-bit captures of SumIn.
- Start while Busy is ignored (no queueing). Start in the same cycle as DONE is ignored; Start is accepted on the next IDLE cycle.
- reset mid-run: on the next edge go to IDLE and zero all registers. The datapath is abandoned and no Done is produced.

## Timing
- Reset values: all enables 0, SEL* 0, SELOffset 0, Busy 0, Done 0, InDato 0, Acumulador 0, Result 0, ErrorOut 0, idx 0, state IDLE.
- Start sampled at edge 0 → LOAD in cycle 1.
  - Neuron k occupies cycles 2+3k .. 4+3k.
  - OFFSET is in cycle 2+3·Neurons; DONE follows one cycle later.
  - Latency from Start to Done is 3·Neurons+3 cycles: 33 for Neurons=10, 6 for Neurons=1.
- Result updates on the OFFSET→DONE edge, so it is valid in the same cycle Done is high.
- Back-to-back throughput is one run per 3·Neurons+4 cycles, including the one IDLE cycle.

## Configuration
- NN_SEQ_ERR_HALT_EN defined:
  - ErrorIn=1 in MULX, ACT or MULY sets ErrorOut and jumps to DONE, skipping OFFSET.
  - Result is not updated on that run; Done still pulses.
- Not defined: the run always completes and ErrorOut is only recorded.

## Structure
- Package nn_seq_pkg holds:
  - the state enum (IDLE, LOAD, MULX, ACT, MULY, OFFSET, DONE);
  - the 4-bit index width constant;
  - the maximum-neurons constant 10.
- The block is a single FSM module with no sub-modules. The counter and registers are small enough to stay inline.

## Test plan
Bench model: SumIn = Acumulador + (SELOffset ? 0x00200000 : 0x00400000).
- Reset, then Start with DataIn=0x00400000, Neurons=10 → Done exactly 33 cycles later; Result=0x02A00000; InDato=0x00400000 throughout the run; ErrorOut=0.
- Enable/select trace over one run → EnableLoadCoeff high for one cycle; SELCoeffX walks 0..9, each value held 3 cycles; SELOffset high only in cycle 32.
- Start held high continuously → runs accepted at cycles 0, 34, 68; Done pulses only at 33, 67, 101.
- reset asserted in cycle 15 → IDLE next cycle; Acumulador=0, Result=0, Busy=0; no Done pulse.
- ErrorIn pulsed in cycle 8 → ErrorOut=1 until the next Start.
  - Without NN_SEQ_ERR_HALT_EN: Done at cycle 33 and Result updates.
  - With NN_SEQ_ERR_HALT_EN: Done at cycle 9 and Result stays at its previous value.
- Neurons=1 → Done 6 cycles after Start; Result=0x00600000.

Source files
------------

// File: rtl/nn_seq_pkg.sv
// Shared definitions for the neural-network sequencer: FSM state encoding,
// neuron index width and the largest supported hidden-layer size.
package nn_seq_pkg;

  // Neuron index width; also the width of the SELCoeffX / SELCoeffY selects.
  localparam int IDX_W       = 4;

  // Largest number of hidden neurons the index and datapath coefficient
  // banks can address.
  localparam int MAX_NEURONS = 10;

  // One state per datapath phase of a run.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    MULX   = 3'd2,
    ACT    = 3'd3,
    MULY   = 3'd4,
    OFFSET = 3'd5,
    DONE   = 3'd6
  } state_t;

endpackage

// File: rtl/nn_sequence_ctrl.sv
// Sequencer for the single-input, single-output neural-network ALU datapath.
// One run per accepted Start: coefficient load, then for every hidden neuron
// X-multiply / activation / Y-multiply-and-accumulate, then the output offset
// add. Drives every datapath enable and select as a Moore decode of the state
// and the neuron index, and owns the accumulator and result registers.
//
// Build option NN_SEQ_ERR_HALT_EN: when defined, an ErrorIn seen during a
// neuron phase (MULX, ACT, MULY) abandons the run and jumps straight to DONE,
// leaving Result untouched. When undefined the run always completes and the
// error is only recorded in ErrorOut.
module nn_sequence_ctrl
  import nn_seq_pkg::*;
#(
  parameter int Width   = 32,
  parameter int Neurons = 10
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             Start,
  input  logic [Width-1:0] DataIn,
  input  logic [Width-1:0] SumIn,
  input  logic             ErrorIn,
  output logic [Width-1:0] InDato,
  output logic [Width-1:0] Acumulador,
  output logic             EnableLoadCoeff,
  output logic             EnableMulX,
  output logic             EnableRegOutMultCoeffX,
  output logic             EnableFuctAct,
  output logic             EnableRegActFunc,
  output logic             EnableMulY,
  output logic             EnableRegDesplazamiento,
  output logic             EnableSum,
  output logic [IDX_W-1:0] SELCoeffX,
  output logic [IDX_W-1:0] SELCoeffY,
  output logic             SELOffset,
  output logic             Busy,
  output logic             Done,
  output logic [Width-1:0] Result,
  output logic             ErrorOut
);

  // Reject hidden-layer sizes the index cannot walk.
  if (Neurons < 1 || Neurons > MAX_NEURONS) begin : g_bad_neurons
    $error("nn_sequence_ctrl: Neurons must be in 1..%0d", MAX_NEURONS);
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(Neurons - 1);

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] idx;
  logic             last_neuron;

  assign last_neuron = (idx == LAST_IDX);

  // State register with synchronous reset.
  // NOTE: flops are written with <= so every register samples pre-edge values;
  // a blocking = here would let later statements see the updated state.
  always_ff @(posedge CLK) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode; the halt build short-circuits neuron phases to DONE.
  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (Start) state_next = LOAD;
      LOAD:    state_next = MULX;
      MULX:    state_next = ACT;
      ACT:     state_next = MULY;
      MULY:    state_next = last_neuron ? OFFSET : MULX;
      OFFSET:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
`ifdef NN_SEQ_ERR_HALT_EN
    if (ErrorIn && (state == MULX || state == ACT || state == MULY))
      state_next = DONE;
`endif
  end

  // Run registers: sample capture, neuron index, accumulator, result and the
  // sticky error flag. Start while busy is simply not looked at.
  always_ff @(posedge CLK) begin
    if (reset) begin
      InDato     <= '0;
      idx        <= '0;
      Acumulador <= '0;
      Result     <= '0;
      ErrorOut   <= 1'b0;
    end else if (state == IDLE) begin
      if (Start) begin
        InDato     <= DataIn;
        idx        <= '0;
        Acumulador <= '0;
        ErrorOut   <= 1'b0;
      end
    end else begin
      ErrorOut <= ErrorOut | ErrorIn;
      if (state == MULY) begin
        Acumulador <= SumIn;
        if (!last_neuron) idx <= idx + IDX_W'(1);
      end
      if (state == OFFSET) Result <= SumIn;
    end
  end

  // Selects track the neuron index at all times so they only move on
  // neuron transitions.
  assign SELCoeffX = idx;
  assign SELCoeffY = idx;

  // Moore decode of datapath enables and handshake outputs.
  always_comb begin
    EnableLoadCoeff         = 1'b0;
    EnableMulX              = 1'b0;
    EnableRegOutMultCoeffX  = 1'b0;
    EnableFuctAct           = 1'b0;
    EnableRegActFunc        = 1'b0;
    EnableMulY              = 1'b0;
    EnableRegDesplazamiento = 1'b0;
    EnableSum               = 1'b0;
    SELOffset               = 1'b0;
    Busy                    = (state != IDLE);
    Done                    = 1'b0;
    unique case (state)
      LOAD: EnableLoadCoeff = 1'b1;
      MULX: begin
        EnableMulX             = 1'b1;
        EnableRegOutMultCoeffX = 1'b1;
      end
      ACT: begin
        EnableFuctAct    = 1'b1;
        EnableRegActFunc = 1'b1;
      end
      MULY: begin
        EnableMulY              = 1'b1;
        EnableRegDesplazamiento = 1'b1;
        EnableSum               = 1'b1;
      end
      OFFSET: begin
        EnableSum = 1'b1;
        SELOffset = 1'b1;
      end
      DONE:    Done = 1'b1;
      default: ;
    endcase
  end

endmodule
